// File: rtl/wb_commit_regfile_pkg.sv
// Shared constants and types for the writeback commit / register file block.
// Holds data width, register index width, halt encoding, FSM states and ABI indices.
package wb_commit_regfile_pkg;

    localparam int          XLEN        = 64;
    localparam int          NREG        = 32;
    localparam int          REG_AW      = 5;
    localparam logic [31:0] EBREAK_INST = 32'h00100073;
    localparam logic [4:0]  A0          = 5'd10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } mon_state_e;

endpackage

// File: rtl/wb_commit_regfile_core.sv
// wb_regfile_core: register array with hardwired x0, one write port and
// two combinational read ports (optional WB->ID forwarding via REGFILE_BYPASS_EN).
// Ports: clk, rst (sync, active-high), we_i/waddr_i/wdata_i write port,
//        rs1/rs2 address in, data out, a0_o raw x10 contents for the monitor.
import wb_commit_regfile_pkg::*;

module wb_regfile_core #(
    parameter int W = wb_commit_regfile_pkg::XLEN,
    parameter int N = wb_commit_regfile_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic [W-1:0]      rs1_data_o,
    output logic [W-1:0]      rs2_data_o,
    output logic [W-1:0]      a0_o
);

    logic [W-1:0] regs_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rs1_data_o = (rs1_addr_i == '0) ? '0 : regs_q[rs1_addr_i];
        rs2_data_o = (rs2_addr_i == '0) ? '0 : regs_q[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
        // we_i already folds in commit, so HALT suppresses forwarding.
        if (we_i && (waddr_i != '0) && (waddr_i == rs1_addr_i)) begin
            rs1_data_o = wdata_i;
        end
        if (we_i && (waddr_i != '0) && (waddr_i == rs2_addr_i)) begin
            rs2_data_o = wdata_i;
        end
`endif
    end

    assign a0_o = regs_q[A0];

endmodule

// File: rtl/wb_commit_regfile.sv
// Writeback commit stage: register file, retired-instruction counter and
// halt monitor (ebreak / unknown opcode) latching a pass/fail verdict.
// Ports: clk, rst (sync, active-high); i_WB_* writeback bundle; i_ID_rs*_addr /
//        o_ID_rs*_data read ports; o_commit_cnt, o_halt, o_halt_good,
//        o_halt_pc, o_halt_code monitor outputs. Option macro: REGFILE_BYPASS_EN.
import wb_commit_regfile_pkg::*;

module wb_commit_regfile #(
    parameter int          XLEN        = wb_commit_regfile_pkg::XLEN,
    parameter int          NREG        = wb_commit_regfile_pkg::NREG,
    parameter logic [31:0] EBREAK_INST = wb_commit_regfile_pkg::EBREAK_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_WB_valid,
    input  logic              i_WB_RegWrite,
    input  logic [REG_AW-1:0] i_WB_reg_wr_addr,
    input  logic [XLEN-1:0]   i_WB_reg_wr_data,
    input  logic [63:0]       i_WB_pc,
    input  logic [31:0]       i_WB_inst,
    input  logic              i_WB_unkown_code,
    input  logic [REG_AW-1:0] i_ID_rs1_addr,
    input  logic [REG_AW-1:0] i_ID_rs2_addr,
    output logic [XLEN-1:0]   o_ID_rs1_data,
    output logic [XLEN-1:0]   o_ID_rs2_data,
    output logic [63:0]       o_commit_cnt,
    output logic              o_halt,
    output logic              o_halt_good,
    output logic [63:0]       o_halt_pc,
    output logic [XLEN-1:0]   o_halt_code
);

    mon_state_e      state_q, state_d;
    logic [63:0]     cnt_q, cnt_d;
    logic            good_q, good_d;
    logic [63:0]     hpc_q, hpc_d;
    logic [XLEN-1:0] hcode_q, hcode_d;

    logic            commit;
    logic            wr_en;
    logic            is_ebreak;
    logic [XLEN-1:0] a0_raw;
    logic [XLEN-1:0] a0_eff;

    assign commit    = i_WB_valid && (state_q == RUN);
    assign wr_en     = commit && i_WB_RegWrite;
    assign is_ebreak = (i_WB_inst == EBREAK_INST);

    wb_regfile_core #(
        .W (XLEN),
        .N (NREG)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_en),
        .waddr_i    (i_WB_reg_wr_addr),
        .wdata_i    (i_WB_reg_wr_data),
        .rs1_addr_i (i_ID_rs1_addr),
        .rs2_addr_i (i_ID_rs2_addr),
        .rs1_data_o (o_ID_rs1_data),
        .rs2_data_o (o_ID_rs2_data),
        .a0_o       (a0_raw)
    );

    // Halt verdict must see the halting instruction's own write to a0.
    assign a0_eff = (wr_en && (i_WB_reg_wr_addr == A0)) ?
                    i_WB_reg_wr_data : a0_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        good_d  = good_q;
        hpc_d   = hpc_q;
        hcode_d = hcode_q;
        if (commit) begin
            cnt_d = cnt_q + 64'd1;
            if (is_ebreak || i_WB_unkown_code) begin
                state_d = HALT;
                hpc_d   = i_WB_pc;
                hcode_d = a0_eff;
                good_d  = is_ebreak && !i_WB_unkown_code &&
                          (a0_eff == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            good_q  <= 1'b0;
            hpc_q   <= '0;
            hcode_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            hpc_q   <= hpc_d;
            hcode_q <= hcode_d;
        end
    end

    assign o_commit_cnt = cnt_q;
    assign o_halt       = (state_q == HALT);
    assign o_halt_good  = good_q;
    assign o_halt_pc    = hpc_q;
    assign o_halt_code  = hcode_q;

endmodule

// File: doc/wb_commit_regfile.md
Name: wb_commit_regfile

Overview:
- Receiving end of the writeback interface: consumes the WB stage outputs (write data, write enable, destination, pc, inst, unknown-code flag).
- Holds the 32x64 integer register file, committing writes from WB and serving two combinational read ports to ID.
- Contains a commit monitor that counts retired instructions and halts on ebreak or an unknown opcode. The halt state latches a pass/fail verdict for the simulation environment.

Parameters:
- XLEN, 64, register and data width
- NREG, 32, number of architectural registers; x0 hardwired to zero
- EBREAK_INST, 32'h00100073, encoding treated as the halt instruction

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_WB_valid  in  1  WB slot holds a real instruction (0 = bubble)
- i_WB_RegWrite  in  1  write enable from WB
- i_WB_reg_wr_addr  in  5  destination register index
- i_WB_reg_wr_data  in  XLEN  data to write
- i_WB_pc  in  64  pc of the WB instruction
- i_WB_inst  in  32  raw instruction word in WB
- i_WB_unkown_code  in  1  WB instruction failed decode
- i_ID_rs1_addr  in  5  read port 1 index
- i_ID_rs2_addr  in  5  read port 2 index
- o_ID_rs1_data  out  XLEN  read port 1 data, combinational
- o_ID_rs2_data  out  XLEN  read port 2 data, combinational
- o_commit_cnt  out  64  retired-instruction count
- o_halt  out  1  monitor in HALT state
- o_halt_good  out  1  halted by ebreak with a0 (x10) == 0
- o_halt_pc  out  64  pc of the halting instruction
- o_halt_code  out  XLEN  x10 value at halt (after the halting instruction's own write)

Behaviour:
- Reset (rst=1 at a clk edge):
  - all 32 registers cleared to 0
  - o_commit_cnt=0, o_halt=0, o_halt_good=0, o_halt_pc=0, o_halt_code=0
  - FSM enters RUN
  - reset asserted while HALT returns to RUN
- Commit condition:
  - commit = i_WB_valid && state==RUN
  - bubbles (i_WB_valid=0) never write, never count, never halt
- Write:
  - on commit && i_WB_RegWrite && addr!=0, reg[addr] <= data at the clk edge
  - writes to x0 are discarded
  - write latency 1 cycle
- Read:
  - combinational; index 0 always returns 0
  - without bypass, a read of the register being written this cycle returns the old value
- Counter:
  - o_commit_cnt += 1 on every commit, including the halting instruction
  - 64-bit, wraps modulo 2^64
- FSM has two states, RUN and HALT.
  - RUN -> HALT when commit && (i_WB_inst==EBREAK_INST || i_WB_unkown_code)
  - At that edge, latch o_halt_pc <= i_WB_pc.
  - At that edge, latch o_halt_code <= the effective x10 value, i.e. i_WB_reg_wr_data if this instruction writes x10, else reg[10].
  - At that edge, latch o_halt_good <= (ebreak && !unkown_code && effective x10==0).
  - A simultaneous ebreak and unkown_code counts as a bad halt.
  - HALT -> RUN only on rst.
  - In HALT: no writes, no counting, halt outputs frozen; read ports still operate.
- Outputs o_halt* change only on the transition edge or at reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: read ports forward i_WB_reg_wr_data when commit && i_WB_RegWrite && wr_addr!=0 && wr_addr==rs_addr. ID then sees the same-cycle WB result. Forwarding is suppressed in HALT and for x0.
- Undefined: plain array read; ID/hazard logic must cover the WB->ID same-cycle case by stalling one cycle.

Decomposition:
- Shared pipeline package holds:
  - XLEN
  - register index width (5)
  - EBREAK_INST
  - FSM state encoding (RUN=1'b0, HALT=1'b1)
  - ABI index constant A0=10
- One natural sub-module, wb_regfile_core: register array, x0 rule, write port and the two read ports including the bypass mux. The commit counter and FSM stay in the top.

Test Plan:
- Reset then write x5=64'hDEAD_BEEF (valid=1, RegWrite=1); next cycle read rs1=5 -> 64'hDEAD_BEEF, o_commit_cnt=1.
- Write x0=64'h1234 -> rs1=0 reads 0; bubble with RegWrite=1 to x6 -> x6 stays 0, count unchanged.
- Same cycle: write x7=64'h55, rs2=7 -> 64'h55 with REGFILE_BYPASS_EN, old value 0 without.
- x10=0, then ebreak at pc=64'h8000_0010 -> o_halt=1, o_halt_good=1, o_halt_pc=64'h8000_0010, count includes the ebreak. A later write to x3 is ignored.
- unkown_code=1 at pc=64'h8000_0020 with x10=3 -> o_halt=1, o_halt_good=0, o_halt_code=3. Then rst=1 for one cycle -> all outputs 0, RUN, registers read 0.
- Halting instruction itself writes x10=0 (with ebreak encoding) -> o_halt_code=0, o_halt_good=1.
